// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 10X1 detector: valid/ready word intake and one
// registered bit per clock on x_out, with an optional idle gap after each word.
module seq_bit_serializer #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_BIT   = 1'b0,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_gap_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_x_out;
   logic             r_x_valid;
   logic             r_word_done;

   logic             w_last_bit;
   logic             w_din_ready;
   logic             w_accept;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_load_rest;
   logic [WIDTH-1:0] w_shift_rest;

   // The first bit goes straight to x_out on accept; r_shift holds only the bits still to send.
   assign w_first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
   assign w_load_rest  = MSB_FIRST ? (din << 1) : (din >> 1);
   assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
   assign w_shift_rest = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

   assign w_last_bit  = (r_state == S_SHIFT) && (r_cnt == LAST_IDX);
   assign w_din_ready = (r_state == S_IDLE) || (w_last_bit && (GAP_CYCLES == 0));
   assign w_accept    = din_valid && w_din_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_gap_cnt   <= '0;
         r_shift     <= '0;
         r_x_out     <= IDLE_BIT;
         r_x_valid   <= 1'b0;
         r_word_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_SHIFT;
                  r_cnt       <= '0;
                  r_shift     <= w_load_rest;
                  r_x_out     <= w_first_bit;
                  r_x_valid   <= 1'b1;
                  r_word_done <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (!w_last_bit) begin
                  r_cnt       <= r_cnt + 1'b1;
                  r_shift     <= w_shift_rest;
                  r_x_out     <= w_next_bit;
                  r_word_done <= ((r_cnt + 1'b1) == LAST_IDX);
               end else if (GAP_CYCLES != 0) begin
                  r_state     <= S_GAP;
                  r_gap_cnt   <= 4'd1;
                  r_cnt       <= '0;
                  r_x_out     <= IDLE_BIT;
                  r_x_valid   <= 1'b0;
                  r_word_done <= 1'b0;
               end else if (w_accept) begin
                  // Back-to-back word: first bit follows the last one with no bubble.
                  r_cnt       <= '0;
                  r_shift     <= w_load_rest;
                  r_x_out     <= w_first_bit;
                  r_x_valid   <= 1'b1;
                  r_word_done <= 1'b0;
               end else begin
                  r_state     <= S_IDLE;
                  r_cnt       <= '0;
                  r_x_out     <= IDLE_BIT;
                  r_x_valid   <= 1'b0;
                  r_word_done <= 1'b0;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state   <= S_IDLE;
                  r_gap_cnt <= '0;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign din_ready = w_din_ready;
   assign x_out     = r_x_out;
   assign x_valid   = r_x_valid;
   assign word_done = r_word_done;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: three configurations share one stimulus stream and are
// checked each cycle against a queue-of-future-outputs model, plus table and directed cases.
module tb_seq_bit_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       din_valid = 1'b0;
   logic [3:0] din = 4'd0;

   logic [2:0] w_rdy, w_x, w_v, w_done, w_busy;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u_a (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(w_rdy[0]),
      .x_out(w_x[0]), .x_valid(w_v[0]), .word_done(w_done[0]), .busy(w_busy[0]));
   seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP_CYCLES(0)) u_b (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(w_rdy[1]),
      .x_out(w_x[1]), .x_valid(w_v[1]), .word_done(w_done[1]), .busy(w_busy[1]));
   seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(3)) u_c (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(w_rdy[2]),
      .x_out(w_x[2]), .x_valid(w_v[2]), .word_done(w_done[2]), .busy(w_busy[2]));

   typedef struct packed {
      logic x;
      logic v;
      logic done;
   } entry_t;

   typedef struct {
      logic       r;
      logic       v;
      logic [3:0] d;
      logic       ex;
      logic       ev;
      logic       ed;
      logic       er;
   } vec_t;

   // Each queue holds the output every upcoming cycle will show; empty means idle.
   entry_t mq[3][$];
   int     p_msb[3]  = '{1, 0, 1};
   int     p_idle[3] = '{0, 1, 0};
   int     p_gap[3]  = '{0, 0, 3};
   int     n_checks  = 0;
   int     n_errors  = 0;
   vec_t   tbl[14];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s idx=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   function automatic logic model_rdy(input int i);
      return (mq[i].size() == 0) || (p_gap[i] == 0 && mq[i].size() == 1);
   endfunction

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         logic   r;
         entry_t e;
         r = model_rdy(i);
         if (reset) begin
            mq[i].delete();
         end else begin
            if (mq[i].size() != 0) void'(mq[i].pop_front());
            if (din_valid && r) begin
               for (int k = 0; k < 4; k++) begin
                  e.x    = din[(p_msb[i] != 0) ? 3 - k : k];
                  e.v    = 1'b1;
                  e.done = (k == 3);
                  mq[i].push_back(e);
               end
               for (int g = 0; g < p_gap[i]; g++) begin
                  e.x    = (p_idle[i] != 0);
                  e.v    = 1'b0;
                  e.done = 1'b0;
                  mq[i].push_back(e);
               end
            end
         end
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 3; i++) begin
         entry_t e;
         if (mq[i].size() != 0) begin
            e = mq[i][0];
         end else begin
            e.x    = (p_idle[i] != 0);
            e.v    = 1'b0;
            e.done = 1'b0;
         end
         chk("x_out", i, w_x[i], e.x);
         chk("x_valid", i, w_v[i], e.v);
         chk("word_done", i, w_done[i], e.done);
         chk("din_ready", i, w_rdy[i], model_rdy(i));
         chk("busy", i, w_busy[i], mq[i].size() != 0);
      end
   endtask

   // Inputs change at the falling edge, the model advances at the rising edge,
   // outputs are compared at the next falling edge.
   task automatic step(input logic r, input logic v, input logic [3:0] d);
      reset     = r;
      din_valid = v;
      din       = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                               input logic ex, input logic ev, input logic ed, input logic er);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.ex = ex; t.ev = ev; t.ed = ed; t.er = er;
      return t;
   endfunction

   initial begin
      logic [3:0] seq;

      // Expected outputs of the MSB-first, no-gap instance after each row's clock edge.
      tbl[0]  = mk(1, 0, 4'b0000, 0, 0, 0, 1);
      tbl[1]  = mk(0, 1, 4'b1001, 1, 1, 0, 0);
      tbl[2]  = mk(0, 0, 4'b0000, 0, 1, 0, 0);
      tbl[3]  = mk(0, 0, 4'b0000, 0, 1, 0, 0);
      tbl[4]  = mk(0, 0, 4'b0000, 1, 1, 1, 1);
      tbl[5]  = mk(0, 1, 4'b1010, 1, 1, 0, 0);
      tbl[6]  = mk(0, 1, 4'b0110, 0, 1, 0, 0);
      tbl[7]  = mk(0, 1, 4'b0110, 1, 1, 0, 0);
      tbl[8]  = mk(0, 1, 4'b0110, 0, 1, 1, 1);
      tbl[9]  = mk(0, 1, 4'b0110, 0, 1, 0, 0);
      tbl[10] = mk(0, 0, 4'b0000, 1, 1, 0, 0);
      tbl[11] = mk(0, 0, 4'b0000, 1, 1, 0, 0);
      tbl[12] = mk(0, 0, 4'b0000, 0, 1, 1, 1);
      tbl[13] = mk(0, 0, 4'b0000, 0, 0, 0, 1);

      @(negedge clk);
      for (int k = 0; k < 14; k++) begin
         step(tbl[k].r, tbl[k].v, tbl[k].d);
         chk("tbl_x_out", k, w_x[0], tbl[k].ex);
         chk("tbl_x_valid", k, w_v[0], tbl[k].ev);
         chk("tbl_word_done", k, w_done[0], tbl[k].ed);
         chk("tbl_din_ready", k, w_rdy[0], tbl[k].er);
         $display("tbl row %0d: in r=%0b v=%0b d=%b -> x=%0b v=%0b done=%0b rdy=%0b",
                  k, tbl[k].r, tbl[k].v, tbl[k].d, w_x[0], w_v[0], w_done[0], w_rdy[0]);
      end

      // LSB-first word 1101 should come out as 1,0,1,1.
      step(1, 0, 4'd0);
      step(0, 1, 4'b1101);
      seq[3] = w_x[1];
      for (int k = 2; k >= 0; k--) begin
         step(0, 0, 4'd0);
         seq[k] = w_x[1];
      end
      chk("lsb_first_bits", 1, seq, 4'b1011);
      chk("lsb_first_done", 1, w_done[1], 1'b1);
      $display("lsb word 1101 -> serial %b", seq);

      // Three-cycle gap after a word, ready returns on the fourth.
      step(1, 0, 4'd0);
      step(0, 1, 4'b1001);
      for (int k = 0; k < 3; k++) step(0, 0, 4'd0);
      chk("gap_last_done", 2, w_done[2], 1'b1);
      for (int g = 0; g < 3; g++) begin
         step(0, 1, 4'b0011);
         chk("gap_x_valid", g, w_v[2], 1'b0);
         chk("gap_x_out", g, w_x[2], 1'b0);
         chk("gap_din_ready", g, w_rdy[2], 1'b0);
      end
      step(0, 0, 4'd0);
      chk("gap_ready_back", 2, w_rdy[2], 1'b1);
      $display("gap case: ready after gap = %0b", w_rdy[2]);

      // Reset on the second bit aborts the word; the next word is accepted at once.
      step(1, 0, 4'd0);
      step(0, 1, 4'b1111);
      step(0, 0, 4'd0);
      step(1, 0, 4'd0);
      chk("abort_x_valid", 0, w_v[0], 1'b0);
      chk("abort_busy", 0, w_busy[0], 1'b0);
      chk("abort_word_done", 0, w_done[0], 1'b0);
      step(0, 1, 4'b0101);
      chk("after_abort_valid", 0, w_v[0], 1'b1);
      chk("after_abort_x", 0, w_x[0], 1'b0);
      for (int k = 0; k < 3; k++) step(0, 0, 4'd0);
      $display("abort case: restart word accepted, busy=%0b", w_busy[0]);

      // Idle stream after reset.
      step(1, 0, 4'd0);
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 4'd0);
         chk("idle_x_out", k, w_x[0], 1'b0);
         chk("idle_ready", k, w_rdy[0], 1'b1);
         chk("idle_busy", k, w_busy[0], 1'b0);
      end
      $display("idle case: 20 idle cycles checked");

      // Random traffic with occasional reset, checked against the model every cycle.
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      end
      $display("random phase: 600 cycles applied");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
